data_ram: RTL and testbench

Word-addressed synchronous data memory: the responder on the load/store port driven by the memory-access pipeline stage. It accepts one request at a time under chip enable, applies a configurable number of wait cycles, then commits a byte-masked write or returns a read word together with a single-cycle acknowledge. While a request is outstanding it raises a stall request to the pipeline controller, so the pipeline freezes until the response returns.

---
 rtl/data_ram_pkg.sv | 25 ++
 rtl/data_ram_lane.sv | 51 +++++
 rtl/data_ram.sv | 126 ++++++++++++
 tb/tb_data_ram.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/data_ram_pkg.sv
// data_ram_pkg
// Shared constants and types for the data_ram load/store responder:
// bus widths, enable encodings, the zero word and the FSM state type.
package data_ram_pkg;

    localparam int DATA_W = 32;   // data bus width
    localparam int ADDR_W = 32;   // byte address bus width
    localparam int SEL_W  = 4;    // byte-lane enables
    localparam int LANE_W = 8;    // bits per byte lane
    localparam int CNT_W  = 3;    // wait counter, enough for LATENCY up to 7

    localparam logic CHIP_ENABLE   = 1'b1;
    localparam logic CHIP_DISABLE  = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam logic [DATA_W-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        DRAM_IDLE = 2'd0,
        DRAM_WAIT = 2'd1,
        DRAM_ACK  = 2'd2
    } dram_state_e;

endpackage

// File: rtl/data_ram_lane.sv
// data_ram_lane
// One byte lane of the data memory: 8 bits x 2^ADDR_WIDTH entries with a
// write enable and a registered read port.
//   clk      : clock
//   rst      : synchronous reset, active low (clears the read register only;
//              array contents survive reset)
//   we_i     : write wdata_i to addr_i at this edge
//   re_i     : load the addressed byte into the read register at this edge;
//              otherwise the read register is cleared
//   addr_i   : word address
//   wdata_i  : write byte
//   rdata_o  : registered read byte
module data_ram_lane
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [LANE_W-1:0]     wdata_i,
    output logic [LANE_W-1:0]     rdata_o
);

    logic [LANE_W-1:0] mem_q [2**ADDR_WIDTH];
    logic [LANE_W-1:0] rdata_q;

    // Storage array kept free of reset so it maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    // Read register holds data only for the cycle after a read strobe,
    // so the bus reads zero everywhere except the acknowledge cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end else begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_ram.sv
// data_ram
// Word-addressed data memory answering the memory-access stage. Accepts one
// request at a time, waits LATENCY cycles (1..7), then commits a byte-masked
// write or returns the read word with a one-cycle acknowledge. Stall request
// is held to the pipeline while a request is outstanding.
//   clk         : clock
//   rst         : synchronous reset, active low
//   mem_ce_i    : request valid, held with all fields until acknowledge
//   mem_we_i    : 1 = write, 0 = read
//   mem_addr_i  : byte address; [ADDR_WIDTH+1:2] selects the word
//   mem_sel_i   : byte-lane write enables
//   mem_data_i  : write data
//   mem_data_o  : read data, nonzero only in the acknowledge cycle
//   mem_ack_o   : one-cycle response pulse
//   stallreq_o  : mem_ce_i & ~mem_ack_o (combinational)
module data_ram
    import data_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,
    parameter int LATENCY    = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ce_i,
    input  logic              mem_we_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [SEL_W-1:0]  mem_sel_i,
    input  logic [DATA_W-1:0] mem_data_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic              mem_ack_o,
    output logic              stallreq_o
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    dram_state_e           state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  ack_q;
    logic                  commit;
    logic                  wr_commit;
    logic                  rd_commit;
    logic [ADDR_WIDTH-1:0] word_addr;
    logic                  unused_addr;

    // Upper address bits alias; byte offset is ignored.
    assign word_addr   = mem_addr_i[ADDR_WIDTH+1:2];
    assign unused_addr = ^{mem_addr_i[ADDR_W-1:ADDR_WIDTH+2], mem_addr_i[1:0]};

    // The counter is loaded with LATENCY-1 at acceptance and reaches 0 on
    // the edge that enters ACK, which places the acknowledge in cycle
    // t+LATENCY. commit marks that edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            DRAM_IDLE: begin
                if (mem_ce_i == CHIP_ENABLE) begin
                    if (LATENCY == 1) begin
                        state_d = DRAM_ACK;
                        commit  = 1'b1;
                    end else begin
                        state_d = DRAM_WAIT;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            DRAM_WAIT: begin
                if (mem_ce_i == CHIP_DISABLE) begin
                    // Initiator withdrew: no write, no acknowledge.
                    state_d = DRAM_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q <= CNT_W'(1)) begin
                    state_d = DRAM_ACK;
                    cnt_d   = '0;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DRAM_ACK: begin
                state_d = DRAM_IDLE;
            end
            default: begin
                state_d = DRAM_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= DRAM_IDLE;
            cnt_q   <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= (state_d == DRAM_ACK);
        end
    end

    // Write strobes are masked by rst so a commit edge under reset is inert.
    assign wr_commit = commit & (mem_we_i == WRITE_ENABLE) & rst;
    assign rd_commit = commit & (mem_we_i == WRITE_DISABLE);

    // Each lane's read register clears unless strobed, so mem_data_o is zero
    // after a write commit and outside the acknowledge cycle.
    for (genvar n = 0; n < SEL_W; n++) begin : g_lane
        data_ram_lane #(
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst    (rst),
            .we_i   (wr_commit & mem_sel_i[n]),
            .re_i   (rd_commit),
            .addr_i (word_addr),
            .wdata_i(mem_data_i[LANE_W*n +: LANE_W]),
            .rdata_o(mem_data_o[LANE_W*n +: LANE_W])
        );
    end

    assign mem_ack_o  = ack_q;
    assign stallreq_o = mem_ce_i & ~ack_q;

endmodule

// File: tb/tb_data_ram.sv
// tb_data_ram
// Three data_ram instances (LATENCY 1, 3, 4) share clock and reset. Each
// access pushes its expected read data and acknowledge cycle onto a
// scoreboard; a negedge monitor pops and compares on every acknowledge.
module tb_data_ram;

    localparam int NDUT = 3;

    logic        clk;
    logic        rst;
    logic        ce    [NDUT];
    logic        we    [NDUT];
    logic [31:0] addr  [NDUT];
    logic [3:0]  sel   [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        stall [NDUT];

    typedef struct {
        int          d;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   n_vec;
    int   n_err;
    logic prev_ack [NDUT];

    data_ram #(.ADDR_WIDTH(10), .LATENCY(1)) u_dut0 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[0]), .mem_we_i(we[0]), .mem_addr_i(addr[0]),
        .mem_sel_i(sel[0]), .mem_data_i(wdata[0]), .mem_data_o(rdata[0]),
        .mem_ack_o(ack[0]), .stallreq_o(stall[0]));
    data_ram #(.ADDR_WIDTH(10), .LATENCY(3)) u_dut1 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[1]), .mem_we_i(we[1]), .mem_addr_i(addr[1]),
        .mem_sel_i(sel[1]), .mem_data_i(wdata[1]), .mem_data_o(rdata[1]),
        .mem_ack_o(ack[1]), .stallreq_o(stall[1]));
    data_ram #(.ADDR_WIDTH(10), .LATENCY(4)) u_dut2 (
        .clk(clk), .rst(rst), .mem_ce_i(ce[2]), .mem_we_i(we[2]), .mem_addr_i(addr[2]),
        .mem_sel_i(sel[2]), .mem_data_i(wdata[2]), .mem_data_o(rdata[2]),
        .mem_ack_o(ack[2]), .stallreq_o(stall[2]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic int lat(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 4;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s act=%h exp=%h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Scoreboard consumer: every acknowledge must match the oldest entry.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (ack[d] === 1'b1) begin
                chk("ack_twice", {31'd0, prev_ack[d]}, 32'd0);
                if (sb.size() == 0) begin
                    chk("spurious_ack", sb.size(), 32'd1);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("ack_dut", d, e.d);
                    chk("ack_cycle", cyc, e.due);
                    chk("rdata", rdata[d], e.data);
                end
            end
            prev_ack[d] <= ack[d];
        end
    end

    // Called at posedge+1; returns at posedge+1 of the cycle after the ack.
    task automatic access(input int d, input logic w, input logic [31:0] a,
                          input logic [3:0] s, input logic [31:0] wd,
                          input logic [31:0] exp_d, input bit keep, output int ack_cyc);
        int t;
        bit got;
        t       = cyc;
        ack_cyc = -1;
        got     = 1'b0;
        we[d] = w; addr[d] = a; sel[d] = s; wdata[d] = wd; ce[d] = 1'b1;
        sb.push_back('{d, exp_d, t + lat(d)});
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            if (ack[d] === 1'b1) begin
                got     = 1'b1;
                ack_cyc = cyc;
                chk("stall_at_ack", {31'd0, stall[d]}, 32'd0);
            end else begin
                chk("stall_wait", {31'd0, stall[d]}, 32'd1);
            end
        end
        if (!got) begin
            chk("ack_timeout", {31'd0, got}, 32'd1);
            if (sb.size() > 0) sb.delete(sb.size() - 1);
        end
        @(posedge clk); #1;
        ce[d] = keep;
    endtask

    initial begin
        int c1, c2, t;
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            ce[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; sel[d] = '0; wdata[d] = '0;
            prev_ack[d] = 1'b0;
        end

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_ack", {31'd0, ack[d]}, 32'd0);
            chk("rst_data", rdata[d], 32'd0);
            chk("rst_stall", {31'd0, stall[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;

        // LATENCY=1: write/read, byte masking, sel=0 write, full-word read
        access(0, 1'b1, 32'h100, 4'hF, 32'h12345678, 32'h0,        1'b0, c1);
        access(0, 1'b0, 32'h100, 4'hF, 32'h0,        32'h12345678, 1'b0, c1);
        access(0, 1'b1, 32'h100, 4'h5, 32'hAABBCCDD, 32'h0,        1'b0, c1);
        access(0, 1'b0, 32'h100, 4'h1, 32'h0,        32'h12BB56DD, 1'b0, c1);
        access(0, 1'b1, 32'h100, 4'h0, 32'hFFFFFFFF, 32'h0,        1'b0, c1);
        access(0, 1'b0, 32'h100, 4'h0, 32'h0,        32'h12BB56DD, 1'b0, c1);

        // LATENCY=1: commit edge coinciding with reset must not write
        access(0, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, c1);
        we[0] = 1'b1; addr[0] = 32'h40; sel[0] = 4'hF; wdata[0] = 32'hDEADBEEF;
        ce[0] = 1'b1; rst = 1'b0;
        @(posedge clk); #1;
        ce[0] = 1'b0; rst = 1'b1;
        chk("rstcommit_ack", {31'd0, ack[0]}, 32'd0);
        chk("rstcommit_data", rdata[0], 32'd0);
        @(posedge clk); #1;
        access(0, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, c1);

        // LATENCY=4: latency, stall window and address aliasing
        access(2, 1'b1, 32'h0000_0004, 4'hF, 32'hCAFEF00D, 32'h0,        1'b0, c1);
        access(2, 1'b0, 32'h0000_1005, 4'h0, 32'h0,        32'hCAFEF00D, 1'b0, c1);

        // LATENCY=3: reset mid-wait
        access(1, 1'b1, 32'h40, 4'hF, 32'h0BADF00D, 32'h0, 1'b0, c1);
        we[1] = 1'b1; addr[1] = 32'h40; sel[1] = 4'hF; wdata[1] = 32'hDEADBEEF; ce[1] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; ce[1] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        chk("rstwait_ack", {31'd0, ack[1]}, 32'd0);
        chk("rstwait_data", rdata[1], 32'd0);
        access(1, 1'b0, 32'h40, 4'hF, 32'h0, 32'h0BADF00D, 1'b0, c1);

        // LATENCY=3: abort in cycle t+1; next request accepted at t+2
        access(1, 1'b1, 32'h200, 4'hF, 32'h11111111, 32'h0, 1'b0, c1);
        t = cyc;
        we[1] = 1'b1; addr[1] = 32'h200; sel[1] = 4'hF; wdata[1] = 32'h99999999; ce[1] = 1'b1;
        @(posedge clk); #1;
        ce[1] = 1'b0;
        @(posedge clk); #1;
        chk("abort_idle_cycle", cyc, t + 2);
        access(1, 1'b0, 32'h200, 4'hF, 32'h0, 32'h11111111, 1'b0, c1);

        // LATENCY=3: back-to-back reads with mem_ce_i held
        access(1, 1'b1, 32'h100, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, c1);
        access(1, 1'b1, 32'h104, 4'hF, 32'h5A5A5A5A, 32'h0, 1'b0, c1);
        access(1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hA5A5A5A5, 1'b1, c1);
        access(1, 1'b0, 32'h104, 4'hF, 32'h0, 32'h5A5A5A5A, 1'b0, c2);
        chk("b2b_gap", c2 - c1, lat(1) + 1);

        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("sb_empty", sb.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
